// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// keccak_pkg : shared constants and absorb-FSM state type for the sponge
// Revision   : 1.0
// ============================================================================
package keccak_pkg;

  localparam int         LANE_W       = 64;
  localparam int         NUM_LANES    = 25;
  localparam logic [7:0] PAD_END_BYTE = 8'h80;

  // Rates in 64-bit lanes.
  localparam int RATE_SHA3_224 = 18;
  localparam int RATE_SHA3_256 = 17;
  localparam int RATE_SHA3_384 = 13;
  localparam int RATE_SHA3_512 = 9;
  localparam int RATE_SHAKE128 = 21;
  localparam int RATE_SHAKE256 = 17;

  typedef enum logic [2:0] {
    ABSORB = 3'd0,
    PDOM   = 3'd1,
    PEND   = 3'd2,
    PSTART = 3'd3,
    PWAIT  = 3'd4,
    DONE   = 3'd5
  } absorb_state_e;

  function automatic logic [3:0] sat_keep(input logic [3:0] keep);
    return (keep > 4'd8) ? 4'd8 : keep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_pad_mask.sv
`default_nettype none
// ============================================================================
// keccak_pad_mask : byte keep-mask plus domain / 0x80 pad insertion
// Revision        : 1.0
// ============================================================================
module keccak_pad_mask
  import keccak_pkg::*;
#(
  parameter logic [7:0] DOMAIN = 8'h06
) (
  input  logic [LANE_W-1:0] data,
  input  logic [3:0]        keep,
  input  logic              is_last,
  input  logic              is_final_lane,
  output logic [LANE_W-1:0] xor_word
);

  logic [3:0] keep_s;
  logic       add_pad;

  assign keep_s  = sat_keep(keep);
  assign add_pad = is_last && (keep_s < 4'd8);

  genvar b;
  generate
    for (b = 0; b < 8; b++) begin : g_byte
      logic [7:0] pad_byte;
      logic [7:0] data_byte;
      // Domain byte lands right after the last kept byte; 0x80 only in byte 7.
      assign pad_byte  = ((add_pad && (keep_s == 4'(b))) ? DOMAIN : 8'h00) |
                         ((add_pad && is_final_lane && (b == 7)) ? PAD_END_BYTE : 8'h00);
      assign data_byte = (keep_s > 4'(b)) ? data[8*b +: 8] : 8'h00;
      assign xor_word[8*b +: 8] = data_byte | pad_byte;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/keccak_absorb_ctrl.sv
`default_nettype none
// ============================================================================
// keccak_absorb_ctrl : absorb-phase sequencer with SHA-3 padding for Keccak-f
// Revision           : 1.0
// ============================================================================
module keccak_absorb_ctrl
  import keccak_pkg::*;
#(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_keep,
  output logic        st_we,
  output logic [4:0]  st_lane,
  output logic [63:0] st_xor,
  output logic        perm_start,
  input  logic        perm_done,
  output logic        busy,
  output logic        absorb_done,
  output logic [15:0] blk_cnt
);

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  absorb_state_e state, state_n;
  logic [4:0]    idx, idx_n;
  logic          pad_pend, pad_pend_n;
  logic          fin, fin_n;
  logic [15:0]   blk_cnt_n;
  logic          we_n;
  logic [4:0]    lane_n;
  logic [63:0]   xor_n;

  logic          at_last_lane;
  logic          hs;
  logic          short_last;
  logic [63:0]   pm_data;
  logic [3:0]    pm_keep;
  logic          pm_last;
  logic [63:0]   pm_xor;

  assign at_last_lane = (idx == LAST_IDX);
  assign hs           = in_valid && in_ready && (state == ABSORB);
  assign short_last   = in_last && (sat_keep(in_keep) < 4'd8);

  // PDOM reuses the pad inserter as an empty last word.
  assign pm_data = (state == PDOM) ? 64'h0 : in_data;
  assign pm_keep = (state == PDOM) ? 4'd0  : in_keep;
  assign pm_last = (state == PDOM) ? 1'b1  : in_last;

  keccak_pad_mask #(
    .DOMAIN (DOMAIN)
  ) u_pad_mask (
    .data          (pm_data),
    .keep          (pm_keep),
    .is_last       (pm_last),
    .is_final_lane (at_last_lane),
    .xor_word      (pm_xor)
  );

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    pad_pend_n = pad_pend;
    fin_n      = fin;
    blk_cnt_n  = blk_cnt;
    we_n       = 1'b0;
    lane_n     = 5'd0;
    xor_n      = 64'h0;
    case (state)
      ABSORB: begin
        if (hs) begin
          we_n   = 1'b1;
          lane_n = idx;
          xor_n  = pm_xor;
          if (at_last_lane) begin
            state_n = PSTART;
            idx_n   = 5'd0;
            if (in_last) begin
              if (short_last) fin_n = 1'b1;
              else            pad_pend_n = 1'b1;
            end
          end else begin
            idx_n = idx + 5'd1;
            if (in_last) state_n = short_last ? PEND : PDOM;
          end
        end
      end
      PDOM: begin
        we_n   = 1'b1;
        lane_n = idx;
        xor_n  = pm_xor;
        if (at_last_lane) begin
          state_n = PSTART;
          idx_n   = 5'd0;
          fin_n   = 1'b1;
        end else begin
          state_n = PEND;
        end
      end
      PEND: begin
        we_n    = 1'b1;
        lane_n  = LAST_IDX;
        xor_n   = {PAD_END_BYTE, 56'h0};
        fin_n   = 1'b1;
        idx_n   = 5'd0;
        state_n = PSTART;
      end
      PSTART: begin
        blk_cnt_n = blk_cnt + 16'd1;
        state_n   = PWAIT;
      end
      PWAIT: begin
        if (perm_done) begin
          idx_n = 5'd0;
          if (pad_pend) begin
            pad_pend_n = 1'b0;
            state_n    = PDOM;
          end else if (fin) begin
            state_n = DONE;
          end else begin
            state_n = ABSORB;
          end
        end
      end
      DONE: begin
        blk_cnt_n = 16'd0;
        fin_n     = 1'b0;
        idx_n     = 5'd0;
        state_n   = ABSORB;
      end
      default: state_n = ABSORB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ABSORB;
      idx         <= 5'd0;
      pad_pend    <= 1'b0;
      fin         <= 1'b0;
      blk_cnt     <= 16'd0;
      in_ready    <= 1'b0;
      st_we       <= 1'b0;
      st_lane     <= 5'd0;
      st_xor      <= 64'h0;
      perm_start  <= 1'b0;
      absorb_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      pad_pend    <= pad_pend_n;
      fin         <= fin_n;
      blk_cnt     <= blk_cnt_n;
      st_we       <= we_n;
      st_lane     <= lane_n;
      st_xor      <= xor_n;
      perm_start  <= (state == PSTART);
      absorb_done <= (state == DONE);
      // Ready/busy follow the state being entered so the handshake lines up.
      in_ready    <= (state_n == ABSORB);
      busy        <= !((state_n == ABSORB) && (idx_n == 5'd0) && !pad_pend_n);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keccak_absorb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keccak_absorb_ctrl : randomized bench with a lane-level padding model
// Revision              : 1.0
// ============================================================================
module tb_keccak_absorb_ctrl;

  localparam int         R   = 17;
  localparam logic [7:0] DOM = 8'h06;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = 64'h0;
  logic        in_last = 1'b0;
  logic [3:0]  in_keep = 4'd0;
  logic        st_we;
  logic [4:0]  st_lane;
  logic [63:0] st_xor;
  logic        perm_start;
  logic        perm_done = 1'b0;
  logic        busy;
  logic        absorb_done;
  logic [15:0] blk_cnt;

  keccak_absorb_ctrl #(
    .RATE_LANES (R),
    .DOMAIN     (DOM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_keep     (in_keep),
    .st_we       (st_we),
    .st_lane     (st_lane),
    .st_xor      (st_xor),
    .perm_start  (perm_start),
    .perm_done   (perm_done),
    .busy        (busy),
    .absorb_done (absorb_done),
    .blk_cnt     (blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lane;
    logic [63:0] val;
    int          blk;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_w;
  int  checks = 0;
  int  errors = 0;
  int  perms_seen = 0;
  int  done_seen = 0;
  int  exp_perms = 0;
  bit  in_perm = 1'b0;
  bit  slow_perm = 1'b0;
  bit  spur_en = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input int k);
    logic [63:0] r;
    r = d;
    for (int b = 0; b < 8; b++)
      if (b >= k) r[8*b +: 8] = 8'h00;
    return r;
  endfunction

  task automatic push_wr(input int lane, input logic [63:0] v, input int blk);
    wr_t w;
    w.lane = lane;
    w.val  = v;
    w.blk  = blk;
    exp_q.push_back(w);
  endtask

  // Permutation core stand-in, plus occasional stray perm_done while absorbing.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && perm_start) begin
        repeat (slow_perm ? 20 : int'($urandom_range(1, 5))) @(posedge clk);
        #1 if (rst_n) perm_done = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0;
      end else if (rst_n && spur_en && in_ready && $urandom_range(0, 15) == 0) begin
        @(posedge clk);
        #1 perm_done = 1'b1;
        @(posedge clk);
        #1 perm_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      in_perm = 1'b0;
    end else begin
      if (in_perm) begin
        check_val("bp_ready", 64'(in_ready), 64'd0);
        check_val("bp_we", 64'(st_we), 64'd0);
      end
      if (perm_done) in_perm = 1'b0;
      if (st_we) begin
        if (exp_q.size() == 0) begin
          check_val("extra_wr_we", 64'(st_we), 64'd0);
        end else begin
          mon_w = exp_q.pop_front();
          check_val("wr_lane", 64'(st_lane), 64'(mon_w.lane));
          check_val("wr_val", st_xor, mon_w.val);
        end
      end
      if (perm_start) begin
        perms_seen++;
        check_val("blk_cnt", 64'(blk_cnt), 64'(perms_seen));
        if (exp_q.size() > 0)
          check_val("blk_order", 64'(exp_q[0].blk >= perms_seen), 64'd1);
        in_perm = 1'b1;
      end
      if (absorb_done) done_seen++;
    end
  end

  task automatic send_word(input logic [63:0] d, input logic [3:0] k, input logic l);
    int t;
    if ($urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 500);
    if (t >= 500) check_val("hs_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {$urandom, $urandom};
    in_keep  = 4'($urandom_range(0, 15));
  endtask

  // Model: a message occupies consecutive rate lanes; padding starts right after
  // the data (domain byte), 0x80 goes in byte 7 of the block's last rate lane.
  task automatic run_msg(input int nfull, input logic [3:0] lkeep, input bit rnd_keep);
    int          pos, ke, base, t;
    logic [63:0] d, v;
    logic [3:0]  k;
    bit          last;
    pos = 0;
    perms_seen = 0;
    base = done_seen;
    for (int i = 0; i <= nfull; i++) begin
      last = (i == nfull);
      d = {$urandom, $urandom};
      if (last) k = lkeep;
      else if (rnd_keep && $urandom_range(0, 7) == 0) k = 4'($urandom_range(0, 7));
      else k = 4'd8;
      ke = (k > 4'd8) ? 8 : int'(k);
      v = mask_bytes(d, ke);
      if (last && ke < 8) begin
        v[8*ke +: 8] = v[8*ke +: 8] | DOM;
        if (pos % R == R - 1) v[63:56] = v[63:56] | 8'h80;
      end
      push_wr(pos % R, v, pos / R);
      pos++;
      if (last) begin
        if (ke == 8) begin
          v = 64'(DOM);
          if (pos % R == R - 1) v[63:56] = v[63:56] | 8'h80;
          push_wr(pos % R, v, pos / R);
          pos++;
        end
        if (pos % R != 0) begin
          push_wr(R - 1, {8'h80, 56'h0}, pos / R);
          pos = (pos / R + 1) * R;
        end
        exp_perms = pos / R;
      end
      send_word(d, k, last);
    end
    t = 0;
    while (done_seen == base && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_val("done_cnt", 64'(done_seen - base), 64'd1);
    check_val("perm_cnt", 64'(perms_seen), 64'(exp_perms));
    check_val("wr_left", 64'(exp_q.size()), 64'd0);
    check_val("blk_cnt_clr", 64'(blk_cnt), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
    check_val("ready_idle", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ready"}, 64'(in_ready), 64'd0);
    check_val({tag, "_we"}, 64'(st_we), 64'd0);
    check_val({tag, "_lane"}, 64'(st_lane), 64'd0);
    check_val({tag, "_xor"}, st_xor, 64'd0);
    check_val({tag, "_pstart"}, 64'(perm_start), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(absorb_done), 64'd0);
    check_val({tag, "_blk"}, 64'(blk_cnt), 64'd0);
  endtask

  initial begin
    int t;
    #12;
    check_all_zero("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    run_msg(0, 4'd0, 1'b0);    // empty message
    run_msg(0, 4'd3, 1'b0);    // 3 bytes
    run_msg(16, 4'd8, 1'b0);   // exact full block: pad in a fresh block
    run_msg(16, 4'd4, 1'b0);   // domain and 0x80 in the final lane
    run_msg(16, 4'd7, 1'b0);   // domain in byte 7 together with 0x80
    run_msg(15, 4'd8, 1'b0);   // pad lane is the final lane
    run_msg(3, 4'd12, 1'b0);   // keep above 8 saturates
    for (int m = 0; m < 25; m++)
      run_msg(int'($urandom_range(0, 45)), 4'($urandom_range(0, 9)), 1'b1);

    // Reset while the permutation is outstanding.
    spur_en   = 1'b0;
    slow_perm = 1'b1;
    perms_seen = 0;
    push_wr(0, 64'h06, 0);
    push_wr(R - 1, {8'h80, 56'h0}, 0);
    send_word({$urandom, $urandom}, 4'd0, 1'b1);
    t = 0;
    while (perms_seen == 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("pre_rst_perm", 64'(perms_seen), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst_blk", 64'(blk_cnt), 64'd1);
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    perms_seen = 0;
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b1;
    slow_perm = 1'b0;
    spur_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_after_midrst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    run_msg(0, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
